// File: rtl/csr_exec_if.sv
// rtl/csr_exec_if.sv - issue, CSR-file and writeback handshakes of the CSR execution unit
//
// Bundles three handshakes:
//   in_*  : decoded CSR op from issue (valid/ready)
//   csr_* : one-at-a-time request to the CSR file plus its response
//   res_* : buffered result towards writeback (valid/ready)
// slave  = csr_exec side, master = surrounding pipeline / CSR file side.

interface csr_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [4:0]      in_rs1;
    logic [XLEN-1:0] in_rs1_val;
    logic [4:0]      in_rd;
    logic [11:0]     in_csr;

    logic            csr_req_valid;
    logic            csr_req_ready;
    logic [11:0]     csr_req_addr;
    logic [XLEN-1:0] csr_req_data;
    logic [1:0]      csr_req_op;
    logic            csr_req_wen;
    logic            csr_resp_valid;
    logic            csr_resp_exists;
    logic [XLEN-1:0] csr_resp_data;

    logic            res_valid;
    logic            res_ready;
    logic [4:0]      res_rd_idx;
    logic [XLEN-1:0] res_rd_val;
    logic            res_ex_valid;
    logic [3:0]      res_ex_cause;
    logic            res_flush;

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs1_val, in_rd, in_csr,
        output in_ready,
        output csr_req_valid, csr_req_addr, csr_req_data, csr_req_op, csr_req_wen,
        input  csr_req_ready, csr_resp_valid, csr_resp_exists, csr_resp_data,
        output res_valid, res_rd_idx, res_rd_val, res_ex_valid, res_ex_cause, res_flush,
        input  res_ready
    );

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs1_val, in_rd, in_csr,
        input  in_ready,
        input  csr_req_valid, csr_req_addr, csr_req_data, csr_req_op, csr_req_wen,
        output csr_req_ready, csr_resp_valid, csr_resp_exists, csr_resp_data,
        input  res_valid, res_rd_idx, res_rd_val, res_ex_valid, res_ex_cause, res_flush,
        output res_ready
    );
endinterface

// File: rtl/csr_exec.sv
// rtl/csr_exec.sv - multi-cycle CSR execution unit (CSRRW/S/C[I]) with kill and timeout
//
// Decodes a CSR op, runs the legality pre-checks, issues one request to a CSR file
// with variable response latency, and holds the result until writeback takes it.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   kill     : squash the operation in flight (highest priority)
//   priv     : current privilege level (00=U, 01=S, 11=M)
//   bus      : csr_exec_if.slave - in_* issue, csr_* CSR file, res_* writeback
// Parameters: XLEN data width; TIMEOUT response wait limit in cycles (0 = wait forever).
// Optional feature: define CSR_PRIV_CHECK_EN to reject accesses with csr[9:8] > priv.

module csr_exec #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kill,
    input  logic [1:0] priv,
    csr_exec_if.slave  bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t state, state_n;

    // latched operation
    logic [11:0]     op_addr;
    logic [XLEN-1:0] op_data;
    logic [1:0]      op_kind;
    logic            op_wen;
    logic [4:0]      op_rd;

    // buffered result
    logic [XLEN-1:0] r_val;
    logic            r_ex;
    logic            r_flush;

    logic [CW-1:0]   cnt;
    logic            drain_ex;   // DRAIN must end in HOLD with an exception (timeout path)

    // control strobes from the next-state logic
    logic ld_rd, ld_op, ld_ex, ld_resp;
    logic cnt_clr, cnt_inc;
    logic drain_ex_set, drain_ex_clr;

    logic in_wen, in_illegal, priv_bad, timeout_hit;

    // RS/RC with x0 or zimm=0 never write, regardless of rs1_val
    assign in_wen = (bus.in_funct3[1:0] == 2'b01) || (bus.in_rs1 != 5'd0);

`ifdef CSR_PRIV_CHECK_EN
    assign priv_bad = (bus.in_csr[9:8] > priv);
`else
    logic unused_priv;
    assign unused_priv = ^priv;
    assign priv_bad    = 1'b0;
`endif

    // csr[11:10]==11 is the read-only CSR space
    assign in_illegal = (bus.in_funct3[1:0] == 2'b00)
                     || (in_wen && (bus.in_csr[11:10] == 2'b11))
                     || priv_bad;

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        ld_rd        = 1'b0;
        ld_op        = 1'b0;
        ld_ex        = 1'b0;
        ld_resp      = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        drain_ex_set = 1'b0;
        drain_ex_clr = 1'b0;
        case (state)
            S_IDLE: begin
                if (!kill && bus.in_valid) begin
                    ld_rd = 1'b1;
                    if (in_illegal) begin
                        ld_ex   = 1'b1;
                        state_n = S_HOLD;
                    end else begin
                        ld_op   = 1'b1;
                        state_n = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (kill) begin
                    // a request already handed over still owes us a response
                    state_n      = bus.csr_req_ready ? S_DRAIN : S_IDLE;
                    cnt_clr      = 1'b1;
                    drain_ex_clr = 1'b1;
                end else if (bus.csr_req_ready) begin
                    state_n = S_WAIT;
                    cnt_clr = 1'b1;
                end
            end
            S_WAIT: begin
                if (kill) begin
                    state_n      = S_DRAIN;
                    cnt_clr      = 1'b1;
                    drain_ex_clr = 1'b1;
                end else if (bus.csr_resp_valid) begin
                    state_n = S_HOLD;
                    ld_resp = 1'b1;
                end else if (timeout_hit) begin
                    state_n      = S_DRAIN;
                    cnt_clr      = 1'b1;
                    drain_ex_set = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_HOLD: begin
                if (kill || bus.res_ready) begin
                    state_n = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (kill) begin
                    drain_ex_clr = 1'b1;
                    cnt_inc      = 1'b1;
                end else if (bus.csr_resp_valid || timeout_hit) begin
                    // the late response is discarded either way
                    state_n = drain_ex ? S_HOLD : S_IDLE;
                    ld_ex   = drain_ex;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_addr  <= '0;
            op_data  <= '0;
            op_kind  <= '0;
            op_wen   <= 1'b0;
            op_rd    <= '0;
            r_val    <= '0;
            r_ex     <= 1'b0;
            r_flush  <= 1'b0;
            cnt      <= '0;
            drain_ex <= 1'b0;
        end else begin
            if (ld_rd) begin
                op_rd <= bus.in_rd;
            end
            if (ld_op) begin
                op_addr <= bus.in_csr;
                op_data <= bus.in_funct3[2] ? {{(XLEN-5){1'b0}}, bus.in_rs1} : bus.in_rs1_val;
                op_kind <= bus.in_funct3[1:0];
                op_wen  <= in_wen;
            end
            if (ld_ex) begin
                r_val   <= '0;
                r_ex    <= 1'b1;
                r_flush <= 1'b0;
            end else if (ld_resp) begin
                r_val   <= bus.csr_resp_exists ? bus.csr_resp_data : '0;
                r_ex    <= !bus.csr_resp_exists;
                r_flush <= bus.csr_resp_exists && op_wen;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CW'(1);
            end
            if (drain_ex_set) begin
                drain_ex <= 1'b1;
            end else if (drain_ex_clr) begin
                drain_ex <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = (state == S_IDLE);
    assign bus.csr_req_valid = (state == S_REQ);
    assign bus.csr_req_addr  = op_addr;
    assign bus.csr_req_data  = op_data;
    assign bus.csr_req_op    = op_kind;
    assign bus.csr_req_wen   = op_wen;

    assign bus.res_valid     = (state == S_HOLD);
    assign bus.res_rd_idx    = op_rd;
    assign bus.res_rd_val    = r_val;
    assign bus.res_ex_valid  = (state == S_HOLD) && r_ex;
    assign bus.res_ex_cause  = ((state == S_HOLD) && r_ex) ? 4'd2 : 4'd0;
    assign bus.res_flush     = (state == S_HOLD) && r_flush && !r_ex;
endmodule
